// File: rtl/qdr_arb_pkg.sv
// Shared definitions for the QDR multi-port arbiter: index/counter widths and op codes.
package qdr_arb_pkg;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_RD   = 2'd1;
  localparam logic [1:0] OP_WR   = 2'd2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/qdr_arb_tag_fifo.sv
// FIFO of port indices for outstanding reads; pops in issue order as the controller returns data.
module qdr_arb_tag_fifo
  import qdr_arb_pkg::*;
#(
  parameter int TAG_DEPTH = 16,
  parameter int TAG_W     = 2
) (
  input  logic             clk0,
  input  logic             reset,
  input  logic             push_i,
  input  logic [TAG_W-1:0] push_tag_i,
  input  logic             pop_i,
  output logic [TAG_W-1:0] pop_tag_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(TAG_DEPTH);
  localparam int CW = cnt_w(TAG_DEPTH);

  logic [TAG_W-1:0] mem_q [TAG_DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_o    = (cnt_q == CW'(TAG_DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign do_push   = push_i & ~full_o;
  assign do_pop    = pop_i & ~empty_o;
  assign pop_tag_o = mem_q[rptr_q];

  // Pointers wrap naturally because TAG_DEPTH is a power of two.
  always_ff @(posedge clk0) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk0) begin
    if (do_push) mem_q[wptr_q] <= push_tag_i;
  end

endmodule

// File: rtl/qdr_port_arbiter.sv
// Round-robin merge of NUM_PORTS requesters onto the QDR user interface with tagged read returns.
// Define QDR_ARB_RD_PRIORITY_EN to let any eligible read beat every write.
module qdr_port_arbiter
  import qdr_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 18,
  parameter int BW_WIDTH   = 2,
  parameter int ADDR_WIDTH = 22,
  parameter int TAG_DEPTH  = 16
) (
  input  logic                              clk0,
  input  logic                              reset,
  input  logic                              phy_rdy,
  input  logic [NUM_PORTS-1:0]              port_rd_strb,
  input  logic [NUM_PORTS-1:0]              port_wr_strb,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   port_addr,
  input  logic [NUM_PORTS*2*DATA_WIDTH-1:0] port_wr_data,
  input  logic [NUM_PORTS*2*BW_WIDTH-1:0]   port_wr_be,
  output logic [NUM_PORTS-1:0]              port_ack,
  output logic [2*DATA_WIDTH-1:0]           port_rd_data,
  output logic [NUM_PORTS-1:0]              port_rd_dvld,
  output logic                              tag_err,
  output logic                              usr_rd_strb,
  output logic                              usr_wr_strb,
  output logic [ADDR_WIDTH-1:0]             usr_addr,
  output logic [2*DATA_WIDTH-1:0]           usr_wr_data,
  output logic [2*BW_WIDTH-1:0]             usr_wr_be,
  input  logic [2*DATA_WIDTH-1:0]           usr_rd_data,
  input  logic                              usr_rd_dvld
);

  localparam int PW = idx_w(NUM_PORTS);
  localparam int CW = cnt_w(TAG_DEPTH);
  localparam int DW = 2 * DATA_WIDTH;
  localparam int BW = 2 * BW_WIDTH;

  logic [PW-1:0]        rr_q;
  logic [CW-1:0]        outst_q;
  logic [NUM_PORTS-1:0] rd_elig, wr_elig, elig;
  logic [PW-1:0]        win, cand;
  logic                 gnt, rd_ok;
  logic [1:0]           win_op;
  logic                 push, pop;
  logic [PW-1:0]        pop_tag;
  logic                 fifo_full, fifo_empty;

  logic                 usr_rd_strb_q, usr_wr_strb_q;
  logic [ADDR_WIDTH-1:0] usr_addr_q;
  logic [DW-1:0]        usr_wr_data_q, port_rd_data_q;
  logic [BW-1:0]        usr_wr_be_q;
  logic [NUM_PORTS-1:0] port_rd_dvld_q;
  logic                 tag_err_q;

  assign rd_ok = (outst_q < CW'(TAG_DEPTH)) & ~fifo_full;

  // A port holding both strobes presents its read; a blocked read does not expose the write.
  always_comb begin
    rd_elig = {NUM_PORTS{phy_rdy & rd_ok}} & port_rd_strb;
    wr_elig = {NUM_PORTS{phy_rdy}} & port_wr_strb & ~port_rd_strb;
`ifdef QDR_ARB_RD_PRIORITY_EN
    elig = (|rd_elig) ? rd_elig : wr_elig;
`else
    elig = rd_elig | wr_elig;
`endif
  end

  always_comb begin
    gnt  = 1'b0;
    win  = '0;
    cand = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = PW'((int'(rr_q) + i) % NUM_PORTS);
      if (!gnt && elig[cand]) begin
        gnt = 1'b1;
        win = cand;
      end
    end
  end

  always_comb begin
    win_op = OP_NONE;
    if (gnt) win_op = port_rd_strb[win] ? OP_RD : OP_WR;
  end

  assign port_ack = gnt ? (NUM_PORTS'(1) << win) : '0;
  assign push     = (win_op == OP_RD);
  assign pop      = usr_rd_dvld & ~fifo_empty;

  qdr_arb_tag_fifo #(
    .TAG_DEPTH (TAG_DEPTH),
    .TAG_W     (PW)
  ) u_tag_fifo (
    .clk0       (clk0),
    .reset      (reset),
    .push_i     (push),
    .push_tag_i (win),
    .pop_i      (pop),
    .pop_tag_o  (pop_tag),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_ff @(posedge clk0) begin
    if (reset) begin
      rr_q          <= PW'(NUM_PORTS - 1);
      outst_q       <= '0;
      usr_rd_strb_q <= 1'b0;
      usr_wr_strb_q <= 1'b0;
      usr_addr_q    <= '0;
      usr_wr_data_q <= '0;
      usr_wr_be_q   <= '0;
    end else begin
      usr_rd_strb_q <= (win_op == OP_RD);
      usr_wr_strb_q <= (win_op == OP_WR);
      if (gnt) begin
        rr_q          <= win;
        usr_addr_q    <= port_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
        usr_wr_data_q <= port_wr_data[int'(win)*DW +: DW];
        usr_wr_be_q   <= port_wr_be[int'(win)*BW +: BW];
      end
      unique case ({push, pop})
        2'b10:   outst_q <= outst_q + 1'b1;
        2'b01:   outst_q <= outst_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Returns with no outstanding tag are dropped and flagged until the next reset.
  always_ff @(posedge clk0) begin
    if (reset) begin
      port_rd_dvld_q <= '0;
      port_rd_data_q <= '0;
      tag_err_q      <= 1'b0;
    end else begin
      port_rd_dvld_q <= pop ? (NUM_PORTS'(1) << pop_tag) : '0;
      if (pop) port_rd_data_q <= usr_rd_data;
      if (usr_rd_dvld && fifo_empty) tag_err_q <= 1'b1;
    end
  end

  assign usr_rd_strb  = usr_rd_strb_q;
  assign usr_wr_strb  = usr_wr_strb_q;
  assign usr_addr     = usr_addr_q;
  assign usr_wr_data  = usr_wr_data_q;
  assign usr_wr_be    = usr_wr_be_q;
  assign port_rd_dvld = port_rd_dvld_q;
  assign port_rd_data = port_rd_data_q;
  assign tag_err      = tag_err_q;

endmodule

// File: tb/tb_qdr_port_arbiter.sv
// Directed bench for qdr_port_arbiter; expectation for the read-priority case follows QDR_ARB_RD_PRIORITY_EN.
module tb_qdr_port_arbiter;

  localparam int NP  = 4;
  localparam int DW  = 36;
  localparam int AW  = 22;
  localparam int BEW = 4;

  logic              clk0 = 1'b0;
  logic              reset;
  logic              phy_rdy;
  logic [NP-1:0]     port_rd_strb, port_wr_strb;
  logic [NP*AW-1:0]  port_addr;
  logic [NP*DW-1:0]  port_wr_data;
  logic [NP*BEW-1:0] port_wr_be;
  logic [NP-1:0]     port_ack;
  logic [DW-1:0]     port_rd_data;
  logic [NP-1:0]     port_rd_dvld;
  logic              tag_err;
  logic              usr_rd_strb, usr_wr_strb;
  logic [AW-1:0]     usr_addr;
  logic [DW-1:0]     usr_wr_data;
  logic [BEW-1:0]    usr_wr_be;
  logic [DW-1:0]     usr_rd_data;
  logic              usr_rd_dvld;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  qdr_port_arbiter dut (
    .clk0         (clk0),
    .reset        (reset),
    .phy_rdy      (phy_rdy),
    .port_rd_strb (port_rd_strb),
    .port_wr_strb (port_wr_strb),
    .port_addr    (port_addr),
    .port_wr_data (port_wr_data),
    .port_wr_be   (port_wr_be),
    .port_ack     (port_ack),
    .port_rd_data (port_rd_data),
    .port_rd_dvld (port_rd_dvld),
    .tag_err      (tag_err),
    .usr_rd_strb  (usr_rd_strb),
    .usr_wr_strb  (usr_wr_strb),
    .usr_addr     (usr_addr),
    .usr_wr_data  (usr_wr_data),
    .usr_wr_be    (usr_wr_be),
    .usr_rd_data  (usr_rd_data),
    .usr_rd_dvld  (usr_rd_dvld)
  );

  always #5 clk0 = ~clk0;

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    port_rd_strb = '0;
    port_wr_strb = '0;
    usr_rd_dvld  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    phy_rdy     = 1'b0;
    usr_rd_data = '0;
    port_addr   = '0;
    port_wr_data = '0;
    port_wr_be  = '0;
    do_reset();
    #4;
    chk_cnt++; if (port_ack !== 4'b0000) $display("FAIL reset_ack: got %b want 0000", port_ack); else pass_cnt++;
    chk_cnt++; if ({usr_rd_strb, usr_wr_strb} !== 2'b00) $display("FAIL reset_strb: got %b want 00", {usr_rd_strb, usr_wr_strb}); else pass_cnt++;
    chk_cnt++; if (usr_addr !== 22'h0) $display("FAIL reset_addr: got %h want 0", usr_addr); else pass_cnt++;
    chk_cnt++; if (port_rd_dvld !== 4'b0000) $display("FAIL reset_dvld: got %b want 0000", port_rd_dvld); else pass_cnt++;
    chk_cnt++; if (tag_err !== 1'b0) $display("FAIL reset_tag_err: got %b want 0", tag_err); else pass_cnt++;
    chk_cnt++; if (port_rd_data !== 36'h0) $display("FAIL reset_rd_data: got %h want 0", port_rd_data); else pass_cnt++;
  endtask

  task automatic test_single_write();
    tick();
    phy_rdy = 1'b1;
    port_addr[2*AW +: AW]     = 22'h00123;
    port_wr_data[2*DW +: DW]  = 36'hA_5A5A_5A5A;
    port_wr_be[2*BEW +: BEW]  = 4'hC;
    port_wr_strb = 4'b0100;
    #4;
    chk_cnt++; if (port_ack !== 4'b0100) $display("FAIL wr_ack: got %b want 0100", port_ack); else pass_cnt++;
    tick();
    port_wr_strb = '0;
    chk_cnt++; if ({usr_wr_strb, usr_rd_strb} !== 2'b10) $display("FAIL wr_strb: got %b want 10", {usr_wr_strb, usr_rd_strb}); else pass_cnt++;
    chk_cnt++; if (usr_addr !== 22'h00123) $display("FAIL wr_addr: got %h want 00123", usr_addr); else pass_cnt++;
    chk_cnt++; if (usr_wr_data !== 36'hA_5A5A_5A5A) $display("FAIL wr_data: got %h want a5a5a5a5a", usr_wr_data); else pass_cnt++;
    chk_cnt++; if (usr_wr_be !== 4'hC) $display("FAIL wr_be: got %h want c", usr_wr_be); else pass_cnt++;
    #1;
    chk_cnt++; if (port_ack !== 4'b0000) $display("FAIL wr_no_ack: got %b want 0000", port_ack); else pass_cnt++;
    tick();
    chk_cnt++; if (usr_wr_strb !== 1'b0) $display("FAIL wr_one_cycle: got %b want 0", usr_wr_strb); else pass_cnt++;
  endtask

  task automatic test_rr_reads();
    logic [NP-1:0] want;
    do_reset();
    for (int p = 0; p < NP; p++) port_addr[p*AW +: AW] = 22'h100 + 22'(p);
    port_rd_strb = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #4;
      want = 4'b0001 << (k % 4);
      chk_cnt++; if (port_ack !== want) $display("FAIL rr_ack%0d: got %b want %b", k, port_ack, want); else pass_cnt++;
      tick();
      if (k == 4) port_rd_strb = '0;
      chk_cnt++; if (usr_rd_strb !== 1'b1 || usr_addr !== 22'h100 + 22'(k % 4))
        $display("FAIL rr_issue%0d: got strb %b addr %h want 1 %h", k, usr_rd_strb, usr_addr, 22'h100 + 22'(k % 4));
      else pass_cnt++;
    end
    for (int k = 0; k < 5; k++) begin
      usr_rd_dvld = 1'b1;
      usr_rd_data = 36'h1_0000_0000 + 36'(k);
      tick();
      usr_rd_dvld = 1'b0;
      want = 4'b0001 << (k % 4);
      chk_cnt++; if (port_rd_dvld !== want || port_rd_data !== 36'h1_0000_0000 + 36'(k))
        $display("FAIL rr_ret%0d: got dvld %b data %h want %b %h", k, port_rd_dvld, port_rd_data, want, 36'h1_0000_0000 + 36'(k));
      else pass_cnt++;
    end
    tick();
    chk_cnt++; if (port_rd_dvld !== 4'b0000) $display("FAIL rr_ret_idle: got %b want 0000", port_rd_dvld); else pass_cnt++;
    chk_cnt++; if (tag_err !== 1'b0) $display("FAIL rr_tag_err: got %b want 0", tag_err); else pass_cnt++;
  endtask

  task automatic test_tag_full();
    int acks;
    do_reset();
    acks = 0;
    port_rd_strb = 4'b0001;
    for (int k = 0; k < 16; k++) begin
      #4;
      if (port_ack === 4'b0001) acks++;
      tick();
    end
    chk_cnt++; if (acks !== 16) $display("FAIL full_sole_acks: got %0d want 16", acks); else pass_cnt++;
    port_wr_strb = 4'b0010;
    #4;
    chk_cnt++; if (port_ack !== 4'b0010) $display("FAIL full_wr_ack: got %b want 0010", port_ack); else pass_cnt++;
    tick();
    port_wr_strb = '0;
    chk_cnt++; if (usr_wr_strb !== 1'b1) $display("FAIL full_wr_issue: got %b want 1", usr_wr_strb); else pass_cnt++;
    #4;
    chk_cnt++; if (port_ack !== 4'b0000) $display("FAIL full_rd_blocked: got %b want 0000", port_ack); else pass_cnt++;
    tick();
    #4;
    chk_cnt++; if (port_ack !== 4'b0000) $display("FAIL full_rd_blocked2: got %b want 0000", port_ack); else pass_cnt++;
    tick();
    usr_rd_dvld = 1'b1;
    usr_rd_data = 36'h0_0000_0BEE;
    tick();
    usr_rd_dvld = 1'b0;
    chk_cnt++; if (port_rd_dvld !== 4'b0001) $display("FAIL full_ret: got %b want 0001", port_rd_dvld); else pass_cnt++;
    #4;
    chk_cnt++; if (port_ack !== 4'b0001) $display("FAIL full_rd_resume: got %b want 0001", port_ack); else pass_cnt++;
    tick();
    port_rd_strb = '0;
  endtask

  task automatic test_rd_wr_same_port();
    do_reset();
    port_addr[1*AW +: AW] = 22'h2AAAA;
    port_rd_strb = 4'b0010;
    port_wr_strb = 4'b0010;
    #4;
    chk_cnt++; if (port_ack !== 4'b0010) $display("FAIL rw_ack1: got %b want 0010", port_ack); else pass_cnt++;
    tick();
    port_rd_strb = '0;
    chk_cnt++; if ({usr_rd_strb, usr_wr_strb} !== 2'b10) $display("FAIL rw_issue_rd: got %b want 10", {usr_rd_strb, usr_wr_strb}); else pass_cnt++;
    #3;
    chk_cnt++; if (port_ack !== 4'b0010) $display("FAIL rw_ack2: got %b want 0010", port_ack); else pass_cnt++;
    tick();
    port_wr_strb = '0;
    chk_cnt++; if ({usr_rd_strb, usr_wr_strb} !== 2'b01 || usr_addr !== 22'h2AAAA)
      $display("FAIL rw_issue_wr: got %b %h want 01 2aaaa", {usr_rd_strb, usr_wr_strb}, usr_addr);
    else pass_cnt++;
  endtask

  task automatic test_rd_priority();
    do_reset();
    port_addr[0*AW +: AW] = 22'h00010;
    port_addr[3*AW +: AW] = 22'h00033;
    port_wr_strb = 4'b0001;
    port_rd_strb = 4'b1000;
    #4;
`ifdef QDR_ARB_RD_PRIORITY_EN
    chk_cnt++; if (port_ack !== 4'b1000) $display("FAIL prio_ack1: got %b want 1000", port_ack); else pass_cnt++;
    tick();
    port_rd_strb = '0;
    chk_cnt++; if (usr_rd_strb !== 1'b1 || usr_addr !== 22'h00033) $display("FAIL prio_issue1: got %b %h want 1 00033", usr_rd_strb, usr_addr); else pass_cnt++;
    #4;
    chk_cnt++; if (port_ack !== 4'b0001) $display("FAIL prio_ack2: got %b want 0001", port_ack); else pass_cnt++;
`else
    chk_cnt++; if (port_ack !== 4'b0001) $display("FAIL prio_ack1: got %b want 0001", port_ack); else pass_cnt++;
    tick();
    port_wr_strb = '0;
    chk_cnt++; if (usr_wr_strb !== 1'b1 || usr_addr !== 22'h00010) $display("FAIL prio_issue1: got %b %h want 1 00010", usr_wr_strb, usr_addr); else pass_cnt++;
    #4;
    chk_cnt++; if (port_ack !== 4'b1000) $display("FAIL prio_ack2: got %b want 1000", port_ack); else pass_cnt++;
`endif
    tick();
    port_rd_strb = '0;
    port_wr_strb = '0;
  endtask

  task automatic test_tag_err();
    do_reset();
    usr_rd_dvld = 1'b1;
    usr_rd_data = 36'h0_0000_DEAD;
    tick();
    usr_rd_dvld = 1'b0;
    chk_cnt++; if (port_rd_dvld !== 4'b0000) $display("FAIL err_no_dvld: got %b want 0000", port_rd_dvld); else pass_cnt++;
    chk_cnt++; if (tag_err !== 1'b1) $display("FAIL err_set: got %b want 1", tag_err); else pass_cnt++;
    tick();
    tick();
    chk_cnt++; if (tag_err !== 1'b1) $display("FAIL err_sticky: got %b want 1", tag_err); else pass_cnt++;
    do_reset();
    chk_cnt++; if (tag_err !== 1'b0) $display("FAIL err_clear: got %b want 0", tag_err); else pass_cnt++;
  endtask

  task automatic test_phy_rdy();
    do_reset();
    phy_rdy = 1'b0;
    for (int p = 0; p < NP; p++) port_addr[p*AW +: AW] = 22'h300 + 22'(p);
    port_wr_strb = 4'hF;
    for (int k = 0; k < 3; k++) begin
      #4;
      chk_cnt++; if (port_ack !== 4'b0000) $display("FAIL phy_no_ack%0d: got %b want 0000", k, port_ack); else pass_cnt++;
      tick();
      chk_cnt++; if ({usr_rd_strb, usr_wr_strb} !== 2'b00) $display("FAIL phy_no_strb%0d: got %b want 00", k, {usr_rd_strb, usr_wr_strb}); else pass_cnt++;
    end
    phy_rdy = 1'b1;
    #4;
    chk_cnt++; if (port_ack !== 4'b0001) $display("FAIL phy_first_ack: got %b want 0001", port_ack); else pass_cnt++;
    tick();
    port_wr_strb = '0;
    chk_cnt++; if (usr_wr_strb !== 1'b1 || usr_addr !== 22'h300) $display("FAIL phy_first_issue: got %b %h want 1 300", usr_wr_strb, usr_addr); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_rr_reads();
    test_tag_full();
    test_rd_wr_same_port();
    test_rd_priority();
    test_tag_err();
    test_phy_rdy();
    tick();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
